// File: rtl/approx_mul_sweep_ctrl.sv
// Sweep sequencer for a combinational 16x16 signed approximate multiplier.
// Streams every ordered table pair (i outer, j inner) as a tagged product on a valid/ready port.
module approx_mul_sweep_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1000,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_we,
  input  logic [AW-1:0]      tbl_addr,
  input  logic [WIDTH-1:0]   tbl_wdata,
  input  logic [AW-1:0]      len,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic [AW-1:0]      res_i,
  output logic [AW-1:0]      res_j,
  output logic               res_last,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t r_state, w_next;

  logic [WIDTH-1:0]   r_tbl [DEPTH];
  logic [AW-1:0]      r_i, r_j;
  logic [AW:0]        r_len;
  logic [WIDTH-1:0]   r_mul_a, r_mul_b;
  logic [AW-1:0]      r_op_i, r_op_j;
  logic               r_op_last, r_op_valid;
  logic               r_res_valid, r_res_last;
  logic [2*WIDTH-1:0] r_res_data;
  logic [AW-1:0]      r_res_i, r_res_j;

  logic [AW:0] w_len_clip;
  logic        w_start_ok, w_out_free, w_cap, w_op_free, w_issue;
  logic        w_j_end, w_pair_last, w_last_acc;

  // Handshake: a result transfers on any edge where res_valid && res_ready; res_valid
  // and the tagged data stay constant until then, and a new capture may share the accept edge.
  assign w_len_clip  = ({1'b0, len} > DEPTH_L) ? DEPTH_L : {1'b0, len};
  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_out_free  = !r_res_valid || res_ready;
  assign w_cap       = r_op_valid && w_out_free;
  assign w_op_free   = !r_op_valid || w_cap;
  assign w_issue     = (r_state == S_RUN) && w_op_free;
  assign w_j_end     = ({1'b0, r_j} == r_len - (AW+1)'(1));
  assign w_pair_last = w_j_end && ({1'b0, r_i} == r_len - (AW+1)'(1));
  assign w_last_acc  = r_res_valid && res_ready && r_res_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (w_issue && w_pair_last) w_next = S_DRAIN;
      S_DRAIN: if (w_last_acc) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  // Table writes are only accepted while idle, including the cycle that accepts start.
  always_ff @(posedge clk) begin
    if (tbl_we && (r_state == S_IDLE) && ({1'b0, tbl_addr} < DEPTH_L))
      r_tbl[tbl_addr] <= tbl_wdata;
  end

  // Operand register decouples the table read from the multiplier path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i         <= '0;
      r_j         <= '0;
      r_len       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_op_i      <= '0;
      r_op_j      <= '0;
      r_op_last   <= 1'b0;
      r_op_valid  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_data  <= '0;
      r_res_i     <= '0;
      r_res_j     <= '0;
    end else begin
      if (w_start_ok) begin
        r_i   <= '0;
        r_j   <= '0;
        r_len <= w_len_clip;
      end else if (w_issue) begin
        if (w_j_end) begin
          r_j <= '0;
          r_i <= r_i + AW'(1);
        end else begin
          r_j <= r_j + AW'(1);
        end
      end

      if (w_issue) begin
        r_mul_a    <= r_tbl[r_i];
        r_mul_b    <= r_tbl[r_j];
        r_op_i     <= r_i;
        r_op_j     <= r_j;
        r_op_last  <= w_pair_last;
        r_op_valid <= 1'b1;
      end else if (w_cap) begin
        r_mul_a    <= '0;
        r_mul_b    <= '0;
        r_op_valid <= 1'b0;
      end

      if (w_cap) begin
        r_res_data  <= mul_product;
        r_res_i     <= r_op_i;
        r_res_j     <= r_op_j;
        r_res_last  <= r_op_last;
        r_res_valid <= 1'b1;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_i     = r_res_i;
  assign res_j     = r_res_j;
  assign res_last  = r_res_last;

endmodule

// File: tb/tb_approx_mul_sweep_ctrl.sv
// Bench for approx_mul_sweep_ctrl with a 4-entry table and a behavioural approximate multiplier.
module tb_approx_mul_sweep_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int RW    = 2*WIDTH + 2*AW + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tbl_we = 1'b0;
  logic [AW-1:0]      tbl_addr = '0;
  logic [WIDTH-1:0]   tbl_wdata = '0;
  logic [AW-1:0]      len = '0;
  logic               start = 1'b0;
  logic               busy, done;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_product;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [2*WIDTH-1:0] res_data;
  logic [AW-1:0]      res_i, res_j;
  logic               res_last;
  logic [1:0]         dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    int len;
    int rmode;
    int cyc;
    bit poke;
  } sweep_vec_t;

  // Hand products of tbl={3,-2,7,-8}, index i*4+j.
  int exp_prod [16] = '{9, -6, 21, -24, -6, 4, -14, 16, 21, -14, 49, -56, -24, 16, -56, 64};

  approx_mul_sweep_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .len(len), .start(start), .busy(busy), .done(done), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_i(res_i), .res_j(res_j), .res_last(res_last),
    .o_dbg_state(dbg_state)
  );

  // Approximate multiplier model: exact for small operands, low byte truncated otherwise.
  function automatic logic [31:0] approx_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    bit big_a, big_b;
    p = $signed(a) * $signed(b);
    big_a = (a[15:8] != 8'h00) && (a[15:8] != 8'hFF);
    big_b = (b[15:8] != 8'h00) && (b[15:8] != 8'hFF);
    if (big_a || big_b) p[7:0] = 8'h00;
    return p;
  endfunction

  assign mul_product = approx_mul(mul_a, mul_b);

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_pop();
    logic [RW-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL extra_result: got i=%0d j=%0d data=%0h with none expected", res_i, res_j, res_data);
    end else begin
      e = exp_q.pop_front();
      if ({res_data, res_i, res_j, res_last} !== e) begin
        n_err++;
        $display("FAIL result: got {%0h,%0d,%0d,%0b} expected {%0h,%0d,%0d,%0b}",
                 res_data, res_i, res_j, res_last, e[RW-1 -: 2*WIDTH], e[2*AW:AW+1], e[AW:1], e[0]);
      end
    end
  endtask

  task automatic write_tbl(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic push_std(input int l);
    for (int i = 0; i < l; i++)
      for (int j = 0; j < l; j++)
        exp_q.push_back({32'(exp_prod[i*4+j]), AW'(i), AW'(j), (i == l-1) && (j == l-1)});
  endtask

  // Drives one sweep; checks every accept, stall stability, start->done edge count and pulse width.
  task automatic run_sweep(input int len_v, input int rmode, input int exp_cyc, input bit poke,
                           input bit wr_en, input logic [WIDTH-1:0] wr_val);
    int cnt;
    bit stall, ph;
    logic [RW-1:0] held;
    @(negedge clk);
    start = 1'b1; len = AW'(len_v); res_ready = 1'b1; ph = 1'b0; cnt = 0;
    tbl_we = wr_en; tbl_addr = '0; tbl_wdata = wr_val;
    while (1) begin
      if (res_valid && res_ready) check_pop();
      stall = res_valid && !res_ready;
      held  = {res_data, res_i, res_j, res_last};
      @(posedge clk); #1;
      start = 1'b0; tbl_we = 1'b0;
      cnt++;
      @(negedge clk);
      if (stall) chk("stall_hold", {25'd0, res_valid, res_data, res_i, res_j, res_last}, {25'd0, 1'b1, held});
      if (done) break;
      if (cnt >= 200) begin
        n_err++;
        $display("FAIL sweep_timeout: got no done after %0d cycles, required done", cnt);
        break;
      end
      if (rmode == 1) begin ph = !ph; res_ready = !ph; end
      if (poke && cnt == 3) begin
        tbl_we = 1'b1; tbl_addr = '0; tbl_wdata = 16'd100; start = 1'b1; len = AW'(1);
      end
    end
    if (exp_cyc >= 0) chk("start_to_done", 64'(cnt), 64'(exp_cyc));
    chk("busy_in_done", 64'(busy), 64'd1);
    chk("leftover_results", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    res_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
  endtask

  sweep_vec_t vecs [7];

  initial begin
    int k, cnt;
    vecs[0] = '{len: 4, rmode: 0, cyc: 19, poke: 1'b0};
    vecs[1] = '{len: 4, rmode: 1, cyc: -1, poke: 1'b0};
    vecs[2] = '{len: 1, rmode: 0, cyc: 4,  poke: 1'b0};
    vecs[3] = '{len: 0, rmode: 0, cyc: 1,  poke: 1'b0};
    vecs[4] = '{len: 7, rmode: 0, cyc: 19, poke: 1'b0};
    vecs[5] = '{len: 4, rmode: 0, cyc: 19, poke: 1'b1};
    vecs[6] = '{len: 2, rmode: 1, cyc: -1, poke: 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_last", 64'(res_last), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_ij", {58'd0, res_i, res_j}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_operands", {32'd0, mul_a, mul_b}, 64'd0);

    write_tbl(3'd0, 16'd3);
    write_tbl(3'd1, -16'sd2);
    write_tbl(3'd2, 16'd7);
    write_tbl(3'd3, -16'sd8);
    write_tbl(3'd4, 16'd555);

    foreach (vecs[v]) begin
      push_std((vecs[v].len > DEPTH) ? DEPTH : vecs[v].len);
      run_sweep(vecs[v].len, vecs[v].rmode, vecs[v].cyc, vecs[v].poke, 1'b0, '0);
    end

    // Reset after five results aborts the sweep with no done pulse.
    @(negedge clk);
    start = 1'b1; len = AW'(4); res_ready = 1'b1; k = 0; cnt = 0;
    while (k < 5 && cnt < 60) begin
      if (res_valid) begin
        chk("abort_data", {res_data, 26'd0, res_i, res_j}, {32'(exp_prod[k]), 26'd0, AW'(k / 4), AW'(k % 4)});
        k++;
      end
      if (k == 5) break;
      @(posedge clk); #1;
      start = 1'b0; cnt++;
      @(negedge clk);
    end
    chk("abort_count", 64'(k), 64'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(res_valid), 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    push_std(4);
    run_sweep(4, 0, 19, 1'b0, 1'b0, '0);

    // Table write in the start-accept cycle is seen by that sweep.
    exp_q.push_back({32'd25, AW'(0), AW'(0), 1'b1});
    run_sweep(1, 0, 4, 1'b0, 1'b1, 16'd5);
    write_tbl(3'd0, 16'd3);

    // Most-negative operands squared.
    write_tbl(3'd0, 16'h8000);
    exp_q.push_back({32'h4000_0000, AW'(0), AW'(0), 1'b1});
    run_sweep(1, 0, 4, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
